// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
//
// Sequencing controller for a shared n-bit ALU. One command at a time is
// accepted over a valid/ready handshake. The controller reads its operands
// from a 4-entry register file (R0-R3), drives the ALU inputs, waits the
// ALU latency and writes the result back. It then returns the result over
// a valid/ready response channel.
//
// Optional feature macro: ALU_CTRL_FLAGS_EN
//   defined   : sticky carry/zero flags are kept, and ADD/SUB may chain the
//               stored carry into alu_c_in (cmd_chain).
//   undefined : flag_c, flag_z and alu_c_in are constant 0, and cmd_chain
//               is ignored.
//
// Parameters
//   n    datapath width
//   LAT  ALU latency in clk cycles (1..7)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op, cmd_dst            ALU select, destination register
//   cmd_src1, cmd_src2         source registers
//   cmd_use_imm, cmd_imm       immediate replaces operand A
//   cmd_chain                  use stored carry as alu_c_in (flags build)
//   alu_sel, alu_a, alu_b      ALU select and operands
//   alu_c_in                   ALU carry in
//   alu_out, alu_c_out         ALU result and carry out
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_carry        result and raw ALU carry
//   flag_c, flag_z             sticky carry and zero flags
// ---------------------------------------------------------------------------
module alu_ctrl #(
    parameter int n   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_dst,
    input  logic [1:0]   cmd_src1,
    input  logic [1:0]   cmd_src2,
    input  logic         cmd_use_imm,
    input  logic [n-1:0] cmd_imm,
    input  logic         cmd_chain,
    output logic [2:0]   alu_sel,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic         alu_c_in,
    input  logic [n-1:0] alu_out,
    input  logic         alu_c_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_data,
    output logic         rsp_carry,
    output logic         flag_c,
    output logic         flag_z
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;

    // The EXEC counter runs from LAT-1 down to 0, so EXEC lasts LAT cycles.
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    logic [1:0]   r_state;
    logic [2:0]   r_cnt;
    logic [n-1:0] r_rf [0:3];
    logic [1:0]   r_dst;
    logic [2:0]   r_sel;
    logic [n-1:0] r_a;
    logic [n-1:0] r_b;
    logic [n-1:0] r_rsp_data;
    logic         r_rsp_carry;

    logic w_accept;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign alu_sel   = r_sel;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;

    // Sequencer: IDLE -> EXEC (LAT cycles) -> WB (1 cycle) -> RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                        r_cnt   <= CNT_INIT;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_WB: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operands are captured only at the accept edge. The ALU inputs are
    // therefore stable through EXEC and simply hold in every other state.
    // Capturing the sources here also makes src == dst hazard-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 3'd0;
            r_dst <= 2'd0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_sel <= cmd_op;
            r_dst <= cmd_dst;
            r_a   <= cmd_use_imm ? cmd_imm : r_rf[cmd_src1];
            r_b   <= r_rf[cmd_src2];
        end
    end

    // Write-back: the register file and the response registers change only
    // in WB, so a reset before WB leaves no trace of the dropped command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
        end else if (r_state == S_WB) begin
            r_rf[r_dst] <= alu_out;
            r_rsp_data  <= alu_out;
            r_rsp_carry <= alu_c_out;
        end
    end

`ifdef ALU_CTRL_FLAGS_EN
    logic r_c_in;
    logic r_flag_c;
    logic r_flag_z;
    logic w_cmd_arith;
    logic w_lat_arith;

    assign w_cmd_arith = (cmd_op == OP_ADD) || (cmd_op == OP_SUB);
    assign w_lat_arith = (r_sel == OP_ADD) || (r_sel == OP_SUB);
    assign alu_c_in    = r_c_in;
    assign flag_c      = r_flag_c;
    assign flag_z      = r_flag_z;

    // Carry-in is chosen at accept from the flag as it stands then. The
    // carry flag tracks only ADD/SUB, while the zero flag tracks every op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_in   <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            if (w_accept) begin
                r_c_in <= cmd_chain && w_cmd_arith && r_flag_c;
            end
            if (r_state == S_WB) begin
                if (w_lat_arith) begin
                    r_flag_c <= alu_c_out;
                end
                r_flag_z <= (alu_out == '0);
            end
        end
    end
`else
    logic w_unused_chain;

    assign w_unused_chain = cmd_chain;
    assign alu_c_in       = 1'b0;
    assign flag_c         = 1'b0;
    assign flag_z         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl
//
// This bench drives two alu_ctrl instances, one with LAT=1 and one with
// LAT=3. Each instance is paired with a behavioural ALU that delays its
// result by LAT register stages.
//
// A transaction-level model tracks the following for each instance:
//   - the register file
//   - the time of the pending accept
//   - the expected result and flags
// A per-cycle compare process checks the DUT outputs against this model.
// Directed command sequences add literal, hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_ctrl;

    localparam bit FLAGS =
`ifdef ALU_CTRL_FLAGS_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [2:0] MOV  = 3'd0;
    localparam logic [2:0] NOT_ = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] NOR_ = 3'd3;
    localparam logic [2:0] SUB  = 3'd4;
    localparam logic [2:0] NAND_ = 3'd5;
    localparam logic [2:0] AND_ = 3'd6;
    localparam logic [2:0] SLT  = 3'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic [2:0]  cmd_op      [2];
    logic [1:0]  cmd_dst     [2];
    logic [1:0]  cmd_src1    [2];
    logic [1:0]  cmd_src2    [2];
    logic        cmd_use_imm [2];
    logic [31:0] cmd_imm     [2];
    logic        cmd_chain   [2];
    logic [2:0]  alu_sel     [2];
    logic [31:0] alu_a       [2];
    logic [31:0] alu_b       [2];
    logic        alu_c_in    [2];
    logic [31:0] alu_out     [2];
    logic        alu_c_out   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_data    [2];
    logic        rsp_carry   [2];
    logic        flag_c      [2];
    logic        flag_z      [2];

    int n_cmp_m = 0;
    int n_err_m = 0;
    int n_cmp_l = 0;
    int n_err_l = 0;
    int cyc     = 0;

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference ALU. Returns {carry, result}; SUB reports a borrow.
    function automatic logic [32:0] alu_f(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic cin);
        case (op)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, ~a};
            3'd2:    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
            3'd3:    return {1'b0, ~(a | b)};
            3'd4:    return {1'b0, a} - {1'b0, b} - {32'd0, cin};
            3'd5:    return {1'b0, ~(a & b)};
            3'd6:    return {1'b0, a & b};
            default: return {32'd0, ($signed(a) < $signed(b))};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LATV = (g == 0) ? 1 : 3;
        logic [32:0] pipe [LATV];

        always @(posedge clk) begin
            pipe[0] <= alu_f(alu_sel[g], alu_a[g], alu_b[g], alu_c_in[g]);
            for (int i = 1; i < LATV; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end

        assign alu_out[g]   = pipe[LATV-1][31:0];
        assign alu_c_out[g] = pipe[LATV-1][32];

        alu_ctrl #(.n(32), .LAT(LATV)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_op     (cmd_op[g]),
            .cmd_dst    (cmd_dst[g]),
            .cmd_src1   (cmd_src1[g]),
            .cmd_src2   (cmd_src2[g]),
            .cmd_use_imm(cmd_use_imm[g]),
            .cmd_imm    (cmd_imm[g]),
            .cmd_chain  (cmd_chain[g]),
            .alu_sel    (alu_sel[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_c_in   (alu_c_in[g]),
            .alu_out    (alu_out[g]),
            .alu_c_out  (alu_c_out[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_data   (rsp_data[g]),
            .rsp_carry  (rsp_carry[g]),
            .flag_c     (flag_c[g]),
            .flag_z     (flag_z[g])
        );
    end

    // ---------------- transaction-level model ----------------
    logic        m_busy [2];
    int          m_acc  [2];
    logic [2:0]  m_op   [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic        m_cin  [2];
    logic [31:0] m_res  [2];
    logic        m_rc   [2];
    logic        m_fc   [2];
    logic        m_fz   [2];
    logic        m_fc_n [2];
    logic        m_fz_n [2];
    logic [31:0] m_rf   [2][4];

    function automatic logic [31:0] op_a(int d);
        return cmd_use_imm[d] ? cmd_imm[d] : m_rf[d][cmd_src1[d]];
    endfunction

    function automatic logic [31:0] op_b(int d);
        return m_rf[d][cmd_src2[d]];
    endfunction

    function automatic logic is_arith(logic [2:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

    function automatic logic cin_of(int d);
        return FLAGS && cmd_chain[d] && is_arith(cmd_op[d]) && m_fc[d];
    endfunction

    function automatic logic [32:0] model_full(int d);
        return alu_f(cmd_op[d], op_a(d), op_b(d), cin_of(d));
    endfunction

    function automatic logic [31:0] model_val(int d);
        logic [32:0] r;
        r = model_full(d);
        return r[31:0];
    endfunction

    function automatic logic model_carry(int d);
        logic [32:0] r;
        r = model_full(d);
        return r[32];
    endfunction

    // The result becomes visible LAT+1 edges after the accept edge.
    function automatic logic exp_valid(int d);
        return m_busy[d] && (cyc >= m_acc[d] + lat_of(d) + 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_cin[d]  <= 1'b0;
                m_fc[d]   <= 1'b0;
                m_fz[d]   <= 1'b0;
                m_fc_n[d] <= 1'b0;
                m_fz_n[d] <= 1'b0;
                for (int r = 0; r < 4; r++) begin
                    m_rf[d][r] <= 32'd0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (cmd_valid[d]) begin
                        m_busy[d] <= 1'b1;
                        m_acc[d]  <= cyc + 1;
                        m_op[d]   <= cmd_op[d];
                        m_a[d]    <= op_a(d);
                        m_b[d]    <= op_b(d);
                        m_cin[d]  <= cin_of(d);
                        m_res[d]  <= model_val(d);
                        m_rc[d]   <= model_carry(d);
                        m_rf[d][cmd_dst[d]] <= model_val(d);
                        m_fc_n[d] <= FLAGS && (is_arith(cmd_op[d]) ? model_carry(d) : m_fc[d]);
                        m_fz_n[d] <= FLAGS && (model_val(d) == 32'd0);
                    end
                end else if (cyc >= m_acc[d] + lat_of(d) + 1 && rsp_ready[d]) begin
                    m_busy[d] <= 1'b0;
                    m_fc[d]   <= m_fc_n[d];
                    m_fz[d]   <= m_fz_n[d];
                end
            end
        end
    end

    task automatic chk_m(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp_m++;
        if (act !== exp) begin
            n_err_m++;
            $display("FAIL %s dut%0d cyc%0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic chk_l(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp_l++;
        if (act !== exp) begin
            n_err_l++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare, 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            chk_m("cmd_ready", d, 64'(cmd_ready[d]), 64'(!m_busy[d]));
            chk_m("rsp_valid", d, 64'(rsp_valid[d]), 64'(exp_valid(d)));
            if (exp_valid(d)) begin
                chk_m("rsp_data", d, 64'(rsp_data[d]), 64'(m_res[d]));
                chk_m("rsp_carry", d, 64'(rsp_carry[d]), 64'(m_rc[d]));
            end
            chk_m("flag_c", d, 64'(flag_c[d]), 64'(exp_valid(d) ? m_fc_n[d] : m_fc[d]));
            chk_m("flag_z", d, 64'(flag_z[d]), 64'(exp_valid(d) ? m_fz_n[d] : m_fz[d]));
            if (m_busy[d]) begin
                chk_m("alu_sel", d, 64'(alu_sel[d]), 64'(m_op[d]));
                chk_m("alu_a", d, 64'(alu_a[d]), 64'(m_a[d]));
                chk_m("alu_b", d, 64'(alu_b[d]), 64'(m_b[d]));
                chk_m("alu_c_in", d, 64'(alu_c_in[d]), 64'(m_cin[d]));
            end
            if (!rst_n) begin
                chk_m("rst alu_a", d, 64'(alu_a[d]), 64'd0);
                chk_m("rst alu_sel", d, 64'(alu_sel[d]), 64'd0);
                chk_m("rst rsp_data", d, 64'(rsp_data[d]), 64'd0);
                chk_m("rst rsp_carry", d, 64'(rsp_carry[d]), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int d, input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] s1, input logic [1:0] s2, input logic ui,
                        input logic [31:0] imm, input logic ch);
        cmd_op[d]      = op;
        cmd_dst[d]     = dst;
        cmd_src1[d]    = s1;
        cmd_src2[d]    = s2;
        cmd_use_imm[d] = ui;
        cmd_imm[d]     = imm;
        cmd_chain[d]   = ch;
        cmd_valid[d]   = 1'b1;
    endtask

    task automatic wait_accept(input int d, input string nm);
        int t;
        t = 0;
        while (!cmd_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk_l({nm, " accept timeout"}, 64'(cmd_ready[d]), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
    endtask

    // Returns the number of edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input int d, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!rsp_valid[d] && n < 30);
    endtask

    task automatic run_cmd(input int d, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] s1, input logic [1:0] s2, input logic ui,
                           input logic [31:0] imm, input logic ch,
                           input logic [31:0] exp_data, input string nm);
        int n;
        send(d, op, dst, s1, s2, ui, imm, ch);
        wait_accept(d, nm);
        wait_rsp(d, n);
        chk_l({nm, " latency"}, 64'(n), 64'(lat_of(d) + 1));
        chk_l({nm, " data"}, 64'(rsp_data[d]), 64'(exp_data));
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d]   = 1'b0;
            cmd_op[d]      = 3'd0;
            cmd_dst[d]     = 2'd0;
            cmd_src1[d]    = 2'd0;
            cmd_src2[d]    = 2'd0;
            cmd_use_imm[d] = 1'b0;
            cmd_imm[d]     = 32'd0;
            cmd_chain[d]   = 1'b0;
            rsp_ready[d]   = 1'b1;
        end

        repeat (3) @(negedge clk);
        chk_l("reset cmd_ready", 64'(cmd_ready[0]), 64'd1);
        chk_l("reset rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk_l("reset rsp_data", 64'(rsp_data[1]), 64'd0);
        chk_l("reset alu_c_in", 64'(alu_c_in[0]), 64'd0);
        chk_l("reset flag_c", 64'(flag_c[0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load and add, LAT=1
        run_cmd(0, MOV, 2'd1, 2'd0, 2'd0, 1'b1, 32'd5,  1'b0, 32'd5,  "mov5");
        run_cmd(0, MOV, 2'd2, 2'd0, 2'd0, 1'b1, 32'd12, 1'b0, 32'd12, "mov12");
        run_cmd(0, ADD, 2'd3, 2'd1, 2'd2, 1'b0, 32'd0,  1'b0, 32'd17, "add");
        chk_l("add carry", 64'(rsp_carry[0]), 64'd0);
        run_cmd(0, MOV, 2'd0, 2'd3, 2'd0, 1'b0, 32'd0,  1'b0, 32'd17, "r3 readback");

        // Overflow and chain
        run_cmd(0, MOV, 2'd0, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, "movff r0");
        run_cmd(0, MOV, 2'd1, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, "movff r1");
        run_cmd(0, ADD, 2'd2, 2'd0, 2'd1, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFE, "ovf add");
        chk_l("ovf rsp_carry", 64'(rsp_carry[0]), 64'd1);
        chk_l("ovf flag_c", 64'(flag_c[0]), 64'(FLAGS));
        run_cmd(0, ADD, 2'd3, 2'd0, 2'd1, 1'b0, 32'd0, 1'b1,
                FLAGS ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, "chain add");
        chk_l("chain alu_c_in", 64'(alu_c_in[0]), 64'(FLAGS));
        chk_l("chain flag_c", 64'(flag_c[0]), 64'(FLAGS));
        chk_l("chain flag_z", 64'(flag_z[0]), 64'd0);

        // Remaining ops
        run_cmd(0, MOV,   2'd0, 2'd0, 2'd0, 1'b1, 32'h8000_0000, 1'b0, 32'h8000_0000, "mov neg");
        run_cmd(0, MOV,   2'd1, 2'd0, 2'd0, 1'b1, 32'd3,         1'b0, 32'd3,         "mov3");
        run_cmd(0, SLT,   2'd2, 2'd0, 2'd1, 1'b0, 32'd0,         1'b0, 32'd1,         "slt");
        run_cmd(0, AND_,  2'd2, 2'd0, 2'd1, 1'b1, 32'hFF,        1'b0, 32'd3,         "and imm");
        run_cmd(0, NAND_, 2'd2, 2'd0, 2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, "nand imm");
        run_cmd(0, NOT_,  2'd2, 2'd0, 2'd0, 1'b1, 32'd0,         1'b0, 32'hFFFF_FFFF, "not imm");

        // Backpressure
        run_cmd(0, MOV, 2'd0, 2'd0, 2'd0, 1'b1, 32'd1000, 1'b0, 32'd1000, "mov1000");
        run_cmd(0, MOV, 2'd1, 2'd0, 2'd0, 1'b1, 32'd999,  1'b0, 32'd999,  "mov999");
        rsp_ready[0] = 1'b0;
        send(0, SUB, 2'd2, 2'd0, 2'd1, 1'b0, 32'd0, 1'b0);
        wait_accept(0, "sub");
        wait_rsp(0, n);
        chk_l("sub latency", 64'(n), 64'd2);
        send(0, MOV, 2'd3, 2'd0, 2'd0, 1'b1, 32'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_l("bp rsp_valid", 64'(rsp_valid[0]), 64'd1);
            chk_l("bp rsp_data", 64'(rsp_data[0]), 64'd1);
            chk_l("bp cmd_ready", 64'(cmd_ready[0]), 64'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #2;
        chk_l("bp handshake rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk_l("bp handshake cmd_ready", 64'(cmd_ready[0]), 64'd1);
        wait_accept(0, "held mov");
        wait_rsp(0, n);
        chk_l("held mov latency", 64'(n), 64'd2);
        chk_l("held mov data", 64'(rsp_data[0]), 64'd7);
        @(negedge clk);
        @(negedge clk);

        // LAT=3
        run_cmd(1, MOV,  2'd0, 2'd0, 2'd0, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'hAAAA_AAAA, "lat3 movA");
        run_cmd(1, MOV,  2'd1, 2'd0, 2'd0, 1'b1, 32'h5555_5555, 1'b0, 32'h5555_5555, "lat3 mov5");
        run_cmd(1, NOR_, 2'd2, 2'd0, 2'd1, 1'b0, 32'd0,         1'b0, 32'd0,         "lat3 nor");
        chk_l("lat3 flag_z", 64'(flag_z[1]), 64'(FLAGS));

        // Reset mid-EXEC
        send(1, MOV, 2'd0, 2'd0, 2'd0, 1'b1, 32'd421, 1'b0);
        wait_accept(1, "mov421");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_l("midrst rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk_l("midrst cmd_ready", 64'(cmd_ready[1]), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_l("post-rst cmd_ready", 64'(cmd_ready[1]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_l("post-rst rsp_valid", 64'(rsp_valid[1]), 64'd0);
        end
        run_cmd(1, MOV, 2'd3, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0, "r0 after reset");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp_m + n_cmp_l, n_err_m + n_err_l);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
